seq_det_scheduler: RTL and testbench
====================================

# seq_det_scheduler

Time-multiplexed controller that shares one overlapping "1101" sequence-detector core among NUM_CH independent serial bit streams. Each channel has a one-bit input buffer and a saved 2-bit detector context. A round-robin scheduler grants one pending channel per cycle to the shared core and reports detections tagged with the channel index. It sits between the serial front-ends and the event-reporting logic, replacing NUM_CH separate detector instances.

## Interface
- NUM_CH, 4, number of serial channels (2..16)
- CW, $clog2(NUM_CH), channel-index width (derived, not overridden)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clock clk
- enable  in  1  scheduler enable; when low, no grants are issued and buffers hold
- in_valid  in  NUM_CH  per-channel bit valid
- in_data  in  NUM_CH  per-channel serial bit
- in_ready  out  NUM_CH  per-channel buffer empty; a bit is accepted on in_valid & in_ready
- ctx_clear  in  NUM_CH  per-channel synchronous clear of context and buffer
- det_valid  out  1  one-cycle detection pulse
- det_ch  out  CW  channel that completed "1101"; valid only with det_valid
- grant_ch  out  CW  channel serviced this cycle (debug); valid only with grant_valid
- grant_valid  out  1  a channel is serviced this cycle

## Operation
- Per channel: pending flag, buffered bit, ctx state (S0 idle, S1 "1", S2 "11", S3 "110").
- in_ready[i] = ~pending[i]. Accept sets pending[i] and captures in_data[i] at the clock edge.
- Arbitration is combinational over pending & {NUM_CH{enable}}. Search starts at rr_ptr+1 and wraps modulo NUM_CH. The lowest index at or after that point wins. grant_valid = any eligible pending.
- On grant of channel g at the edge:
  - ctx[g] <= next state.
  - pending[g] <= 0.
  - rr_ptr <= g.
  - det_valid <= (ctx[g]==S3 && bit==1).
  - det_ch <= g.
- Without a grant, det_valid <= 0 and det_ch holds.
- Core transitions (overlapping):
  - S0: 1→S1, 0→S0
  - S1: 1→S2, 0→S0
  - S2: 1→S2, 0→S3
  - S3: 1→S1 with detect, 0→S0
- Non-granted channels keep ctx and pending unchanged.
- ctx_clear[i]: ctx[i] <= S0 and pending[i] <= 0. Clear beats a same-cycle accept and a same-cycle grant on channel i. In both cases the bit is dropped and no detection is reported for it. Clear does not move rr_ptr.
- A grant and a new accept cannot coincide on one channel, because in_ready is low while pending.
- enable low: no grant, rr_ptr holds. Accepts still occur into empty buffers.

## Timing
- Reset values:
  - all ctx = S0, pending = 0, rr_ptr = NUM_CH-1 (so channel 0 is searched first)
  - in_ready = all ones
  - det_valid = 0, det_ch = 0, grant_valid = 0, grant_ch = 0
- Reset mid-stream discards all buffered bits and contexts immediately (asynchronous).
- Latency: bit accepted at edge N → granted during cycle N..N+1 at the earliest → det_valid high in the cycle after edge N+1. That is 2 cycles from acceptance, plus arbitration wait.
- Throughput: aggregate 1 bit/cycle. Per channel at most 1 bit every 2 cycles.
- Worst-case wait with all channels pending is NUM_CH-1 cycles (starvation-free).
- Outputs det_valid and det_ch are registered. in_ready, grant_valid and grant_ch are combinational from registers and enable.

## Structure
- Shared package seq_det_pkg holds:
  - state typedef (S0..S3, 2-bit)
  - the function/constants for pattern 1101
- Sub-module seq_det_core: purely combinational next-state and detect, state + bit in → next state + hit out. It is instantiated once and shared.
- The round-robin arbiter stays inline. A separate rr_arbiter is optional if reused elsewhere.

## Test plan
- Single channel 0, stream 1,1,0,1,1,0,1 → det_valid twice, det_ch=0, exercising overlap. The second detection follows 3 bits after the first.
- All 4 channels fed "1101" simultaneously, one bit per 2 cycles → four detections, det_ch order 0,1,2,3. No bit lost; each channel waits ≤3 cycles.
- Channel 2 gets "110", then ctx_clear[2] pulse, then "1" → no detection. Then "1101" → one detection with det_ch=2.
- enable held low with bits pending on channels 1 and 3 → no grants and in_ready[1]=in_ready[3]=0. Raise enable → grants go to 1, then 3.
- Stream "111101" on channel 1 → single detection (S2 self-loop). Stream "1100" → none.
- Assert reset while channels are pending with ctx=S3 → all outputs at reset values at once. A following "1" on any channel produces no detection.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and the "1101" overlapping-match step function for the
// time-multiplexed sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } det_state_t;

    localparam logic [3:0] DET_PATTERN = 4'b1101;

    function automatic det_state_t det_next(input det_state_t s, input logic b);
        det_state_t n;
        n = S0;
        case (s)
            S0: n = b ? S1 : S0;
            S1: n = b ? S2 : S0;
            S2: n = b ? S2 : S3;
            S3: n = b ? S1 : S0;
            default: n = S0;
        endcase
        return n;
    endfunction

    function automatic logic det_hit(input det_state_t s, input logic b);
        return (s == S3) && (b == DET_PATTERN[0]);
    endfunction

endpackage

// File: rtl/seq_det_core.sv
// Combinational "1101" detector step shared by all channels; context lives
// in the scheduler.
//   state | meaning
//   S0    | idle / no useful prefix
//   S1    | seen "1"
//   S2    | seen "11"
//   S3    | seen "110"
module seq_det_core
    import seq_det_pkg::*;
(
    input  det_state_t state,
    input  logic       bit_in,
    output det_state_t next_state,
    output logic       hit
);

    assign next_state = det_next(state, bit_in);
    assign hit        = det_hit(state, bit_in);

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one seq_det_core among NUM_CH serial streams,
// each with a one-bit buffer and a saved detector context.
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CW     = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] in_valid,
    input  logic [NUM_CH-1:0] in_data,
    output logic [NUM_CH-1:0] in_ready,
    input  logic [NUM_CH-1:0] ctx_clear,
    output logic              det_valid,
    output logic [CW-1:0]     det_ch,
    output logic [CW-1:0]     grant_ch,
    output logic              grant_valid
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] buf_bit;
    logic [NUM_CH-1:0] eligible;
    det_state_t        ctx [NUM_CH];
    logic [CW-1:0]     rr_ptr;

    det_state_t cur_state;
    det_state_t core_next;
    logic       cur_bit;
    logic       core_hit;

    assign in_ready = ~pending;
    assign eligible = pending & {NUM_CH{enable}};

    // First eligible channel strictly after the last one served, wrapping.
    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!grant_valid && eligible[(int'(rr_ptr) + k) % NUM_CH]) begin
                grant_valid = 1'b1;
                grant_ch    = CW'((int'(rr_ptr) + k) % NUM_CH);
            end
        end
    end

    assign cur_state = ctx[grant_ch];
    assign cur_bit   = buf_bit[grant_ch];

    seq_det_core u_core (
        .state      (cur_state),
        .bit_in     (cur_bit),
        .next_state (core_next),
        .hit        (core_hit)
    );

    // A grant that collides with a clear still advances the pointer, but its
    // bit is dropped and cannot report a detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= CW'(NUM_CH - 1);
            det_valid <= 1'b0;
            det_ch    <= '0;
        end else begin
            det_valid <= 1'b0;
            if (grant_valid) begin
                rr_ptr    <= grant_ch;
                det_ch    <= grant_ch;
                det_valid <= core_hit & ~ctx_clear[grant_ch];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            buf_bit <= '0;
            for (int i = 0; i < NUM_CH; i++) ctx[i] <= S0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ctx_clear[i]) begin
                    pending[i] <= 1'b0;
                    ctx[i]     <= S0;
                end else if (grant_valid && grant_ch == CW'(i)) begin
                    pending[i] <= 1'b0;
                    ctx[i]     <= core_next;
                end else if (in_valid[i] && !pending[i]) begin
                    pending[i] <= 1'b1;
                    buf_bit[i] <= in_data[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Self-checking bench for seq_det_scheduler: directed scenarios plus random
// traffic, compared every cycle against a bit-history reference model.
module tb_seq_det_scheduler;

    localparam int NUM_CH = 4;
    localparam int CW     = $clog2(NUM_CH);

    logic              clk;
    logic              reset;
    logic              enable;
    logic [NUM_CH-1:0] in_valid;
    logic [NUM_CH-1:0] in_data;
    logic [NUM_CH-1:0] in_ready;
    logic [NUM_CH-1:0] ctx_clear;
    logic              det_valid;
    logic [CW-1:0]     det_ch;
    logic [CW-1:0]     grant_ch;
    logic              grant_valid;

    seq_det_scheduler #(.NUM_CH(NUM_CH)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .ctx_clear   (ctx_clear),
        .det_valid   (det_valid),
        .det_ch      (det_ch),
        .grant_ch    (grant_ch),
        .grant_valid (grant_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: each channel keeps the last four bits it consumed
    // since reset/clear; a detection is exactly "those four bits are 1101".
    bit [NUM_CH-1:0] m_pend;
    bit [NUM_CH-1:0] m_buf;
    logic [3:0]      m_hist [NUM_CH];
    int              m_last;
    bit              m_det_v;
    int              m_det_ch;

    int obs_dets[$];
    int obs_grants[$];
    bit q[NUM_CH][$];

    task automatic model_reset();
        m_pend   = '0;
        m_buf    = '0;
        m_last   = NUM_CH - 1;
        m_det_v  = 1'b0;
        m_det_ch = 0;
        for (int i = 0; i < NUM_CH; i++) m_hist[i] = 4'b0000;
    endtask

    task automatic model_arb(output bit gv, output int gc);
        gv = 1'b0;
        gc = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            int c;
            c = (m_last + k) % NUM_CH;
            if (!gv && enable && m_pend[c]) begin
                gv = 1'b1;
                gc = c;
            end
        end
    endtask

    task automatic model_update(input bit gv, input int gc);
        bit [NUM_CH-1:0] old_pend;
        bit nd;
        old_pend = m_pend;
        nd = 1'b0;
        if (gv) begin
            m_last   = gc;
            m_det_ch = gc;
            m_pend[gc] = 1'b0;
            if (!ctx_clear[gc]) begin
                m_hist[gc] = {m_hist[gc][2:0], m_buf[gc]};
                nd = (m_hist[gc] == 4'b1101);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (ctx_clear[i]) begin
                m_pend[i] = 1'b0;
                m_hist[i] = 4'b0000;
            end else if (in_valid[i] && !old_pend[i]) begin
                m_pend[i] = 1'b1;
                m_buf[i]  = in_data[i];
            end
        end
        m_det_v = nd;
    endtask

    // Called at posedge+1 with inputs already driven; returns at next posedge+1.
    task automatic step();
        bit gv;
        int gc;
        logic [NUM_CH-1:0] rdy_exp;
        #1;
        model_arb(gv, gc);
        rdy_exp = ~m_pend;
        chk("in_ready", in_ready, rdy_exp);
        chk("grant_valid", grant_valid, gv);
        if (gv) chk("grant_ch", grant_ch, gc);
        chk("det_valid", det_valid, m_det_v);
        if (m_det_v) chk("det_ch", det_ch, m_det_ch);
        if (det_valid) obs_dets.push_back(int'(det_ch));
        if (grant_valid) obs_grants.push_back(int'(grant_ch));
        @(posedge clk);
        model_update(gv, gc);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        ctx_clear = '0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid  = '0;
        ctx_clear = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Feed the per-channel queues with valid/ready handshake until drained.
    task automatic run_feed(input int budget);
        int cyc;
        bit busy;
        bit [NUM_CH-1:0] acc;
        cyc  = 0;
        busy = 1'b1;
        while (busy && cyc < budget) begin
            enable    = 1'b1;
            ctx_clear = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                in_valid[i] = (q[i].size() > 0);
                in_data[i]  = (q[i].size() > 0) ? q[i][0] : 1'b0;
                acc[i]      = in_valid[i] && !m_pend[i];
            end
            step();
            for (int i = 0; i < NUM_CH; i++) if (acc[i]) void'(q[i].pop_front());
            cyc++;
            busy = (m_pend != '0);
            for (int i = 0; i < NUM_CH; i++) if (q[i].size() > 0) busy = 1'b1;
        end
        if (busy) chk("feed_budget", cyc, budget + 1);
        idle(2);
    endtask

    task automatic load(input int ch, input string s);
        for (int i = 0; i < s.len(); i++) q[ch].push_back(s[i] == "1");
    endtask

    initial begin
        do_reset();

        // Reset state
        #1;
        chk("rst_in_ready", in_ready, 4'hF);
        chk("rst_det_valid", det_valid, 1'b0);
        chk("rst_det_ch", det_ch, 0);
        chk("rst_grant_valid", grant_valid, 1'b0);
        chk("rst_grant_ch", grant_ch, 0);
        @(posedge clk);
        #1;

        // Overlapping detection on channel 0
        obs_dets.delete();
        load(0, "1101101");
        run_feed(100);
        chk("t1_ndet", obs_dets.size(), 2);
        if (obs_dets.size() >= 2) begin
            chk("t1_ch_a", obs_dets[0], 0);
            chk("t1_ch_b", obs_dets[1], 0);
        end

        // All channels in parallel
        do_reset();
        obs_dets.delete();
        for (int c = 0; c < NUM_CH; c++) load(c, "1101");
        run_feed(200);
        chk("t2_ndet", obs_dets.size(), 4);
        if (obs_dets.size() == 4)
            for (int c = 0; c < NUM_CH; c++) chk("t2_order", obs_dets[c], c);

        // Clear in the middle of a match
        do_reset();
        obs_dets.delete();
        load(2, "110");
        run_feed(100);
        ctx_clear = 4'b0100;
        in_valid  = '0;
        step();
        ctx_clear = '0;
        load(2, "1");
        run_feed(100);
        chk("t3_none", obs_dets.size(), 0);
        load(2, "1101");
        run_feed(100);
        chk("t3_ndet", obs_dets.size(), 1);
        if (obs_dets.size() == 1) chk("t3_ch", obs_dets[0], 2);

        // Enable gating
        do_reset();
        obs_grants.delete();
        enable   = 1'b0;
        in_valid = 4'b1010;
        in_data  = 4'b1010;
        step();
        in_valid = '0;
        step();
        step();
        chk("t4_rdy1", in_ready[1], 1'b0);
        chk("t4_rdy3", in_ready[3], 1'b0);
        chk("t4_nogrant", obs_grants.size(), 0);
        enable = 1'b1;
        step();
        step();
        step();
        chk("t4_ngrant", obs_grants.size(), 2);
        if (obs_grants.size() == 2) begin
            chk("t4_g0", obs_grants[0], 1);
            chk("t4_g1", obs_grants[1], 3);
        end

        // Self-loop on "11" and a near miss
        do_reset();
        obs_dets.delete();
        load(1, "111101");
        run_feed(100);
        chk("t5_ndet", obs_dets.size(), 1);
        load(1, "1100");
        run_feed(100);
        chk("t5_total", obs_dets.size(), 1);

        // Asynchronous reset with every channel armed in S3
        do_reset();
        obs_dets.delete();
        for (int c = 0; c < NUM_CH; c++) load(c, "110");
        run_feed(200);
        enable   = 1'b0;
        in_valid = 4'hF;
        in_data  = 4'hF;
        step();
        enable = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_in_ready", in_ready, 4'hF);
        chk("t6_det_valid", det_valid, 1'b0);
        chk("t6_det_ch", det_ch, 0);
        chk("t6_grant_valid", grant_valid, 1'b0);
        chk("t6_grant_ch", grant_ch, 0);
        model_reset();
        in_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        load(0, "1");
        load(3, "1");
        run_feed(100);
        chk("t6_none", obs_dets.size(), 0);

        // Random traffic
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            enable = ($urandom_range(7) != 0);
            in_valid = NUM_CH'($urandom);
            for (int i = 0; i < NUM_CH; i++) begin
                in_data[i]   = ($urandom_range(3) != 0);
                ctx_clear[i] = ($urandom_range(31) == 0);
            end
            step();
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
